// File: rtl/mul_share_sched.sv
// Round-robin scheduler that shares one shift-and-add multiplier between NREQ requesters.
// The winner's operands are captured, B is consumed LSB first, and the tagged product is returned on a valid/ready port.
module mul_share_sched #(
  parameter  int NREQ = 4,
  parameter  int AW   = 4,
  parameter  int BW   = 3,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*AW-1:0]  a_in,
  input  logic [NREQ*BW-1:0]  b_in,
  output logic [NREQ-1:0]     gnt,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [AW+BW-1:0]    res_data,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  localparam int CW = $clog2(BW + 1);
  localparam int PW = AW + BW;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [PW-1:0]   res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  scan_idx;
  logic [PW-1:0]   pp;

  // Search starts just after the last winner, so a re-requesting winner ends up last.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
  end

  assign gnt = (state_q == IDLE && win_found && !rst)
               ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    busy_d      = busy_q;
    pp          = {{BW{1'b0}}, a_q & {AW{b_q[cnt_q]}}};
    case (state_q)
      IDLE: begin
        if (win_found) begin
          a_d     = a_in[int'(win)*AW +: AW];
          b_d     = b_in[int'(win)*BW +: BW];
          id_d    = win;
          last_d  = win;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
          busy_d  = 1'b1;
        end
      end
      MUL: begin
        acc_d = acc_q + (pp << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = acc_d;
          res_id_d    = id_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule
